// File: rtl/mac_array_axil.sv
// AXI4-Lite controlled array of NCH signed multiply-accumulate channels.
// One shared IDLE->MUL->ACC sequence updates every channel result at once.
module mac_array_axil #(
   parameter int NCH  = 4,
   parameter int DW   = 16,
   parameter int ACCW = 32
) (
   input  logic        clk,
   input  logic        arst,
   input  logic [11:0] s_awaddr,
   input  logic        s_awvalid,
   output logic        s_awready,
   input  logic [31:0] s_wdata,
   input  logic [3:0]  s_wstrb,
   input  logic        s_wvalid,
   output logic        s_wready,
   output logic [1:0]  s_bresp,
   output logic        s_bvalid,
   input  logic        s_bready,
   input  logic [11:0] s_araddr,
   input  logic        s_arvalid,
   output logic        s_arready,
   output logic [31:0] s_rdata,
   output logic [1:0]  s_rresp,
   output logic        s_rvalid,
   input  logic        s_rready,
   output logic        irq
);

   localparam int PW = 2 * DW;

   typedef enum logic [1:0] {IDLE, MUL, ACC} state_t;

   state_t state, state_nx;

   logic signed [DW-1:0]   f1   [NCH];
   logic signed [DW-1:0]   f2   [NCH];
   logic signed [ACCW-1:0] a1   [NCH];
   logic signed [ACCW-1:0] res  [NCH];
   logic signed [PW-1:0]   prod [NCH];

   logic        mode, ie, done, busy;
   logic        aw_full, w_full;
   logic [11:0] aw_addr;
   logic [31:0] w_data;
   logic [3:0]  w_strb;

   logic        wr_en, wr_err, wr_ctrl, wr_stat, wr_chreg;
   logic        wr_start, wr_clr, wr_chok;
   logic [3:0]  wr_ch;
   logic [1:0]  wr_off;
   logic [31:0] rd_data;
   logic        rd_err, rd_chok;
   logic [3:0]  rd_ch;
   logic        unused_bits;

   function automatic logic [31:0] merge(
      input logic [31:0] old,
      input logic [31:0] d,
      input logic [3:0]  s
   );
      logic [31:0] m;
      m = old;
      for (int b = 0; b < 4; b++)
         if (s[b]) m[8*b +: 8] = d[8*b +: 8];
      return m;
   endfunction

   assign busy      = (state != IDLE);
   assign s_awready = ~arst & ~aw_full;
   assign s_wready  = ~arst & ~w_full;
   assign s_arready = ~arst & ~s_rvalid;
   assign irq       = done & ie;

   // A held write waits until the previous response has been taken.
   assign wr_en   = aw_full & w_full & ~s_bvalid;
   assign wr_ch   = aw_addr[7:4];
   assign wr_off  = aw_addr[3:2];
   assign wr_chok = (aw_addr[11:8] == 4'h1) && (int'(wr_ch) < NCH);
   assign rd_ch   = s_araddr[7:4];
   assign rd_chok = (s_araddr[11:8] == 4'h1) && (int'(rd_ch) < NCH);

   assign unused_bits = ^{s_araddr[1:0], aw_addr[1:0]};

   always_comb begin
      wr_ctrl  = 1'b0;
      wr_stat  = 1'b0;
      wr_chreg = 1'b0;
      wr_err   = 1'b0;
      wr_start = 1'b0;
      wr_clr   = 1'b0;
      unique case (1'b1)
         aw_addr[11:2] == 10'd0: begin
            wr_ctrl  = 1'b1;
            wr_start = w_strb[0] & w_data[0] & ~busy;
            wr_clr   = w_strb[0] & w_data[2] & ~busy;
            wr_err   = w_strb[0] & w_data[0] & busy;
         end
         aw_addr[11:2] == 10'd1: wr_stat = 1'b1;
         wr_chok && (wr_off != 2'd3): begin
            wr_chreg = ~busy;
            wr_err   = busy;
         end
         default: wr_err = 1'b1;
      endcase
   end

   always_comb begin
      rd_data = '0;
      rd_err  = 1'b0;
      unique case (1'b1)
         s_araddr[11:2] == 10'd0:
            rd_data = {28'd0, ie, 1'b0, mode, 1'b0};
         s_araddr[11:2] == 10'd1:
            rd_data = {30'd0, done, busy};
         s_araddr[11:2] == 10'd2:
            rd_data = 32'(NCH);
         rd_chok: begin
            for (int c = 0; c < NCH; c++)
               if (rd_ch == 4'(c))
                  case (s_araddr[3:2])
                     2'd0:    rd_data = 32'(f1[c]);
                     2'd1:    rd_data = 32'(f2[c]);
                     2'd2:    rd_data = 32'(a1[c]);
                     default: rd_data = 32'(res[c]);
                  endcase
         end
         default: rd_err = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) state <= IDLE;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (wr_en && wr_start) state_nx = MUL;
         MUL:     state_nx = ACC;
         ACC:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         aw_full  <= 1'b0;
         w_full   <= 1'b0;
         aw_addr  <= '0;
         w_data   <= '0;
         w_strb   <= '0;
         s_bvalid <= 1'b0;
         s_bresp  <= 2'b00;
         s_rvalid <= 1'b0;
         s_rdata  <= '0;
         s_rresp  <= 2'b00;
         mode     <= 1'b0;
         ie       <= 1'b0;
         done     <= 1'b0;
         for (int c = 0; c < NCH; c++) begin
            f1[c]   <= '0;
            f2[c]   <= '0;
            a1[c]   <= '0;
            res[c]  <= '0;
            prod[c] <= '0;
         end
      end else begin
         if (s_awvalid && s_awready) begin
            aw_full <= 1'b1;
            aw_addr <= s_awaddr;
         end
         if (s_wvalid && s_wready) begin
            w_full <= 1'b1;
            w_data <= s_wdata;
            w_strb <= s_wstrb;
         end
         if (s_bvalid && s_bready) s_bvalid <= 1'b0;
         if (wr_en) begin
            aw_full  <= 1'b0;
            w_full   <= 1'b0;
            s_bvalid <= 1'b1;
            s_bresp  <= wr_err ? 2'b10 : 2'b00;
         end

         if (s_rvalid && s_rready) s_rvalid <= 1'b0;
         if (s_arvalid && s_arready) begin
            s_rvalid <= 1'b1;
            s_rdata  <= rd_data;
            s_rresp  <= rd_err ? 2'b10 : 2'b00;
         end

         if (wr_en && wr_ctrl && w_strb[0]) begin
            mode <= w_data[1];
            ie   <= w_data[3];
         end
         if (wr_en && (wr_start || (wr_stat && w_strb[0] && w_data[1])))
            done <= 1'b0;
         if (state == ACC) done <= 1'b1;

         for (int c = 0; c < NCH; c++) begin
            if (wr_en && wr_chreg && wr_ch == 4'(c))
               case (wr_off)
                  2'd0: f1[c] <= DW'(merge(32'(f1[c]), w_data, w_strb));
                  2'd1: f2[c] <= DW'(merge(32'(f2[c]), w_data, w_strb));
                  2'd2: a1[c] <= ACCW'(merge(32'(a1[c]), w_data, w_strb));
                  default: ;
               endcase
            if (state == MUL)
               prod[c] <= PW'(f1[c]) * PW'(f2[c]);
            // Clear only happens while idle, so it never meets an ACC update.
            if (wr_en && wr_clr)
               res[c] <= '0;
            else if (state == ACC)
               res[c] <= mode ? res[c] + ACCW'(prod[c])
                              : ACCW'(prod[c]) + a1[c];
         end
      end
   end

endmodule

// File: tb/tb_mac_array_axil.sv
// Randomized scoreboard bench for mac_array_axil with a register-level
// reference model; responses are checked by an independent monitor.
module tb_mac_array_axil;

   localparam int NCH = 4;

   logic        clk = 1'b0;
   logic        arst = 1'b1;
   logic [11:0] s_awaddr = '0;
   logic        s_awvalid = 1'b0;
   logic        s_awready;
   logic [31:0] s_wdata = '0;
   logic [3:0]  s_wstrb = '0;
   logic        s_wvalid = 1'b0;
   logic        s_wready;
   logic [1:0]  s_bresp;
   logic        s_bvalid;
   logic        s_bready = 1'b1;
   logic [11:0] s_araddr = '0;
   logic        s_arvalid = 1'b0;
   logic        s_arready;
   logic [31:0] s_rdata;
   logic [1:0]  s_rresp;
   logic        s_rvalid;
   logic        s_rready = 1'b1;
   logic        irq;

   always #5 clk = ~clk;

   mac_array_axil #(.NCH(NCH), .DW(16), .ACCW(32)) dut (
      .clk(clk), .arst(arst),
      .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
      .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid),
      .s_wready(s_wready), .s_bresp(s_bresp), .s_bvalid(s_bvalid),
      .s_bready(s_bready), .s_araddr(s_araddr), .s_arvalid(s_arvalid),
      .s_arready(s_arready), .s_rdata(s_rdata), .s_rresp(s_rresp),
      .s_rvalid(s_rvalid), .s_rready(s_rready), .irq(irq)
   );

   int vectors = 0;
   int miscompares = 0;

   logic [1:0]  bq [$];
   logic [33:0] rq [$];
   logic [33:0] re;

   logic [15:0] m_f1 [NCH];
   logic [15:0] m_f2 [NCH];
   logic [31:0] m_a1 [NCH];
   logic [31:0] m_res [NCH];
   bit          m_mode, m_ie, m_done;

   logic [11:0] rpool [9] = '{12'h000, 12'h004, 12'h008, 12'h00C, 12'h0FC,
                              12'h140, 12'h1F0, 12'h200, 12'hFFC};
   logic [11:0] wpool [4] = '{12'h008, 12'h00C, 12'h10C, 12'h140};

   function automatic void check(input string name,
                                 input logic [31:0] act,
                                 input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endfunction

   function automatic void fail_now(input string name);
      vectors++;
      miscompares++;
      $display("FAIL %s: timed out", name);
   endfunction

   function automatic void model_reset();
      for (int c = 0; c < NCH; c++) begin
         m_f1[c] = '0; m_f2[c] = '0; m_a1[c] = '0; m_res[c] = '0;
      end
      m_mode = 0; m_ie = 0; m_done = 0;
   endfunction

   function automatic logic [1:0] model_wr(input logic [11:0] a,
                                           input logic [31:0] d,
                                           input logic [3:0] s,
                                           input bit busy);
      int ch, off, p;
      logic [31:0] m;
      if (a == 12'h000) begin
         if (s[0]) begin
            m_mode = d[1];
            m_ie   = d[3];
            if (busy) return d[0] ? 2'b10 : 2'b00;
            if (d[2])
               for (int c = 0; c < NCH; c++) m_res[c] = '0;
            if (d[0]) begin
               for (int c = 0; c < NCH; c++) begin
                  p = int'($signed(m_f1[c])) * int'($signed(m_f2[c]));
                  m_res[c] = m_mode ? m_res[c] + p : m_a1[c] + p;
               end
               m_done = 1;
            end
         end
         return 2'b00;
      end
      if (a == 12'h004) begin
         if (s[0] && d[1]) m_done = 0;
         return 2'b00;
      end
      if (a >= 12'h100 && int'(a) < 256 + 16 * NCH) begin
         ch  = (int'(a) - 256) / 16;
         off = (int'(a) % 16) / 4;
         if (off == 3 || busy) return 2'b10;
         m = (off == 0) ? 32'($signed(m_f1[ch])) :
             (off == 1) ? 32'($signed(m_f2[ch])) : m_a1[ch];
         for (int b = 0; b < 4; b++)
            if (s[b]) m[8*b +: 8] = d[8*b +: 8];
         if (off == 0) m_f1[ch] = m[15:0];
         else if (off == 1) m_f2[ch] = m[15:0];
         else m_a1[ch] = m;
         return 2'b00;
      end
      return 2'b10;
   endfunction

   function automatic logic [33:0] model_rd(input logic [11:0] a);
      int ch, off;
      if (a == 12'h000) return {2'b00, 28'd0, m_ie, 1'b0, m_mode, 1'b0};
      if (a == 12'h004) return {2'b00, 30'd0, m_done, 1'b0};
      if (a == 12'h008) return {2'b00, 32'(NCH)};
      if (a >= 12'h100 && int'(a) < 256 + 16 * NCH) begin
         ch  = (int'(a) - 256) / 16;
         off = (int'(a) % 16) / 4;
         case (off)
            0:       return {2'b00, 32'($signed(m_f1[ch]))};
            1:       return {2'b00, 32'($signed(m_f2[ch]))};
            2:       return {2'b00, m_a1[ch]};
            default: return {2'b00, m_res[ch]};
         endcase
      end
      return {2'b10, 32'd0};
   endfunction

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [11:0] a, input logic [31:0] d,
                     input logic [3:0] s, input bit busy, input int wd);
      bit aw_done = 0, w_done = 0, aw_hs, w_hs;
      int k = 0, t = 0;
      bq.push_back(model_wr(a, d, s, busy));
      s_awaddr = a; s_awvalid = 1'b1;
      s_wdata = d; s_wstrb = s; s_wvalid = (wd == 0);
      while (!(aw_done && w_done) && t < 50) begin
         @(negedge clk);
         aw_hs = s_awvalid && s_awready;
         w_hs  = s_wvalid && s_wready;
         if (wd > 0 && aw_done && !w_done)
            check("aw_no_reaccept", 32'(s_awready), 32'd0);
         @(posedge clk);
         #1;
         if (aw_hs) begin aw_done = 1; s_awvalid = 1'b0; end
         if (w_hs) begin w_done = 1; s_wvalid = 1'b0; end
         if (aw_done && !w_done && !s_wvalid) begin
            k++;
            if (k >= wd) s_wvalid = 1'b1;
         end
         t++;
      end
      if (!(aw_done && w_done)) begin
         fail_now("wr_handshake");
         s_awvalid = 1'b0; s_wvalid = 1'b0;
      end
   endtask

   task automatic drain(input bit reads);
      int t = 0;
      while ((bq.size() != 0 || (reads && rq.size() != 0)) && t < 200) begin
         @(posedge clk);
         #1;
         t++;
      end
      if (t >= 200) fail_now("drain");
   endtask

   task automatic rd(input logic [11:0] a);
      int t = 0;
      bit hs = 0;
      drain(1'b0);
      rq.push_back(model_rd(a));
      s_araddr = a; s_arvalid = 1'b1;
      while (!hs && t < 50) begin
         @(negedge clk);
         hs = s_arready;
         @(posedge clk);
         #1;
         t++;
      end
      s_arvalid = 1'b0;
      if (!hs) fail_now("rd_handshake");
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_awready"}, 32'(s_awready), 32'd0);
      check({tag, "_wready"},  32'(s_wready),  32'd0);
      check({tag, "_arready"}, 32'(s_arready), 32'd0);
      check({tag, "_bvalid"},  32'(s_bvalid),  32'd0);
      check({tag, "_rvalid"},  32'(s_rvalid),  32'd0);
      check({tag, "_bresp"},   32'(s_bresp),   32'd0);
      check({tag, "_rresp"},   32'(s_rresp),   32'd0);
      check({tag, "_rdata"},   s_rdata,        32'd0);
      check({tag, "_irq"},     32'(irq),       32'd0);
   endtask

   initial forever begin
      @(negedge clk);
      if (!arst && s_bvalid && s_bready) begin
         if (bq.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL bresp: unexpected response %b", s_bresp);
         end else
            check("bresp", 32'(s_bresp), 32'(bq.pop_front()));
      end
      if (!arst && s_rvalid && s_rready) begin
         if (rq.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL rdata: unexpected response %h", s_rdata);
         end else begin
            re = rq.pop_front();
            check("rresp", 32'(s_rresp), 32'(re[33:32]));
            check("rdata", s_rdata, re[31:0]);
         end
      end
   end

   initial begin
      logic [3:0] st;
      bit md, cl;
      model_reset();
      idle(3);
      check_outputs_zero("reset");
      arst = 1'b0;
      idle(1);

      rd(12'h000); rd(12'h004); rd(12'h008);
      for (int c = 0; c < NCH; c++)
         for (int o = 0; o < 4; o++) rd(12'(256 + 16 * c + 4 * o));

      // Mode 0 single MAC on channel 0.
      wr(12'h100, 32'd3, 4'hF, 0, 0);
      wr(12'h104, 32'hFFFF_FFFC, 4'hF, 0, 0);
      wr(12'h108, 32'd100, 4'hF, 0, 0);
      wr(12'h000, 32'h1, 4'hF, 0, 0);
      idle(6);
      rd(12'h10C); rd(12'h004);

      // Accumulate from a cleared result, then past the 32-bit wrap.
      wr(12'h100, 32'h7FFF, 4'hF, 0, 0);
      wr(12'h104, 32'h7FFF, 4'hF, 0, 0);
      wr(12'h000, 32'h7, 4'hF, 0, 0);
      idle(6);
      repeat (2) begin wr(12'h000, 32'h3, 4'hF, 0, 0); idle(6); end
      rd(12'h10C);
      repeat (2) begin wr(12'h000, 32'h3, 4'hF, 0, 0); idle(6); end
      rd(12'h10C); rd(12'h11C);

      // Writes landing while the sequence runs.
      wr(12'h000, 32'h1, 4'hF, 0, 0);
      wr(12'h100, 32'h1234, 4'hF, 1, 0);
      idle(6);
      rd(12'h100); rd(12'h140);
      wr(12'h000, 32'h1, 4'hF, 0, 0);
      wr(12'h000, 32'h1, 4'hF, 1, 0);
      idle(6);
      wr(12'h000, 32'h1, 4'hF, 0, 0);
      wr(12'h000, 32'h4, 4'hF, 1, 0);
      idle(6);
      rd(12'h10C); rd(12'h12C);

      // Interrupt timing and clearing.
      wr(12'h000, 32'h9, 4'hF, 0, 0);
      repeat (3) @(negedge clk);
      check("irq_during_acc", 32'(irq), 32'd0);
      @(negedge clk);
      check("irq_after_done", 32'(irq), 32'd1);
      idle(1);
      wr(12'h004, 32'h2, 4'hF, 0, 0);
      @(negedge clk);
      check("irq_before_w1c", 32'(irq), 32'd1);
      @(negedge clk);
      check("irq_after_w1c", 32'(irq), 32'd0);
      idle(1);
      rd(12'h004); rd(12'h000);

      // Late W data and a stalled response channel.
      s_bready = 1'b0;
      wr(12'h108, 32'h55, 4'hF, 0, 5);
      @(negedge clk);
      check("bvalid_in_write_cycle", 32'(s_bvalid), 32'd0);
      repeat (3) begin
         @(negedge clk);
         check("bvalid_hold", 32'(s_bvalid), 32'd1);
      end
      @(posedge clk);
      #1;
      s_bready = 1'b1;
      rd(12'h108);

      for (int it = 0; it < 20; it++) begin
         for (int c = 0; c < NCH; c++)
            for (int o = 0; o < 3; o++)
               if ($urandom_range(0, 3) != 0) begin
                  st = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'hF;
                  wr(12'(256 + 16 * c + 4 * o), $urandom, st, 0, 0);
               end
         wr(wpool[$urandom_range(0, 3)], $urandom, 4'hF, 0, 0);
         md = 1'($urandom_range(0, 1));
         cl = ($urandom_range(0, 3) == 0);
         wr(12'h000, {28'd0, 1'b0, cl, md, 1'b1}, 4'hF, 0, 0);
         idle(6);
         for (int c = 0; c < NCH; c++) rd(12'(256 + 16 * c + 12));
         rd(12'(256 + 16 * $urandom_range(0, NCH - 1) + 4 * $urandom_range(0, 2)));
         rd(rpool[$urandom_range(0, 8)]);
      end

      // Reset while the multiply stage is active.
      drain(1'b1);
      wr(12'h000, 32'h1, 4'hF, 0, 0);
      @(posedge clk);
      #1;
      arst = 1'b1;
      #1;
      check_outputs_zero("midrst");
      bq.delete();
      rq.delete();
      model_reset();
      idle(2);
      arst = 1'b0;
      rd(12'h10C); rd(12'h004);
      idle(6);
      rd(12'h004); rd(12'h10C); rd(12'h100);

      drain(1'b1);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
